// File: rtl/buck_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buck_pwm_pkg
// Description : Shared types and default constants for the buck PWM driver.
//               Holds the state encoding, which doubles as the status code.
// Revision    : 1.0 - initial release
// ============================================================================
package buck_pwm_pkg;

  // Controller states. The encoding is visible on the status port.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SOFT_START = 2'd1,
    ST_RUN        = 2'd2,
    ST_FAULT      = 2'd3
  } state_t;

  // Default configuration: 2 kHz switching from a 1 MHz clock
  localparam int c_period  = 500;
  localparam int c_max_on  = 460;
  localparam int c_ss_step = 4;
  localparam int c_dead    = 2;

  // Period counter width for the default period
  localparam int c_cnt_w   = $clog2(c_period);

  // On-time arithmetic width; one bit wider than Time_on so that
  // on_shadow + SS_STEP never wraps
  localparam int c_on_w    = 11;

  // Smaller of two on-time values
  function automatic logic [c_on_w-1:0] on_min(input logic [c_on_w-1:0] a,
                                               input logic [c_on_w-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_period_counter
// Description : Free-running modulo-PERIOD counter with a last-cycle flag.
//               Also intended to pace a future ADC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_period_counter
  import buck_pwm_pkg::*;
#(
  parameter int PERIOD = c_period,
  parameter int CNT_W  = $clog2(PERIOD)
) (
  input  logic             clk_1M,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] c_last_val = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count 0..PERIOD-1 and wrap, regardless of controller state
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last_val) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == c_last_val);

endmodule
`default_nettype wire

// File: rtl/buck_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : buck_pwm_gen
// Description : Fixed-period PWM driver for the buck high-side switch with
//               soft-start, latched fault shutdown, on-time clamping, a
//               mid-on-time ADC trigger and a period marker.
//               Define BUCK_PWM_COMP_EN to add the complementary low-side
//               drive pwm_low with DEAD cycles of dead time on each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module buck_pwm_gen
  import buck_pwm_pkg::*;
#(
  parameter int PERIOD  = c_period,
  parameter int MAX_ON  = c_max_on,
  parameter int SS_STEP = c_ss_step,
  parameter int DEAD    = c_dead
) (
  input  logic       clk_1M,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] Time_on,
  input  logic       fault,
  output logic       pwm_out,
  output logic       adc_trig,
  output logic       period_start,
  output logic       ss_done,
  output logic [1:0] status
`ifdef BUCK_PWM_COMP_EN
  ,
  output logic       pwm_low
`endif
);

  // Width of the period counter for this instance's PERIOD
  localparam int c_cw = $clog2(PERIOD);

  localparam logic [c_on_w-1:0] c_max_on_v = c_on_w'(MAX_ON);
  localparam logic [c_on_w-1:0] c_step_v   = c_on_w'(SS_STEP);

  // The on-time must end strictly inside the period, and the 11-bit
  // on-time datapath must be able to represent every counter value.
  if ((MAX_ON >= PERIOD) || (PERIOD > 2047) || (PERIOD < 2) ||
      (SS_STEP < 1) || (DEAD < 0)) begin : g_cfg_check
    $error("buck_pwm_gen: invalid configuration (need MAX_ON < PERIOD <= 2047, SS_STEP >= 1, DEAD >= 0)");
  end

  // --------------------------------------------------------------------------
  // Period counter
  // --------------------------------------------------------------------------
  logic [c_cw-1:0]   w_cnt;
  logic              w_last;
  logic [c_on_w-1:0] w_cnt_ext;

  pwm_period_counter #(
    .PERIOD (PERIOD),
    .CNT_W  (c_cw)
  ) u_period_counter (
    .clk_1M (clk_1M),
    .rst    (rst),
    .cnt    (w_cnt),
    .last   (w_last)
  );

  assign w_cnt_ext = c_on_w'(w_cnt);

  // --------------------------------------------------------------------------
  // On-time targets
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_next_state;
  logic [c_on_w-1:0] r_on_shadow;
  logic [c_on_w-1:0] w_on_next;
  logic [c_on_w-1:0] w_target;
  logic [c_on_w-1:0] w_ss_upd;
  logic              w_active_next;

  // Clamped command and the next soft-start step toward it
  assign w_target = on_min(c_on_w'(Time_on), c_max_on_v);
  assign w_ss_upd = on_min(r_on_shadow + c_step_v, w_target);

  // Switching is allowed only while the controller will be in SOFT_START
  // or RUN; using the next state makes shutdown take effect one cycle after
  // enable drops or fault rises.
  assign w_active_next = (w_next_state == ST_SOFT_START) ||
                         (w_next_state == ST_RUN);

  // --------------------------------------------------------------------------
  // Controller FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; fault overrides everything and FAULT only releases
  // when both fault and enable are low, so restart always soft-starts.
  always_comb begin
    w_next_state = r_state;
    if (fault) begin
      w_next_state = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && w_last) begin
            w_next_state = ST_SOFT_START;
          end
        end
        ST_SOFT_START: begin
          if (!enable) begin
            w_next_state = ST_IDLE;
          end else if (w_last && (w_ss_upd == w_target)) begin
            w_next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            w_next_state = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (!enable) begin
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: next values of the registered outputs
  logic w_pwm_d;
  logic w_adc_d;
  logic w_ps_d;
  logic w_ss_done_d;

  always_comb begin
    w_pwm_d     = w_active_next && (w_cnt_ext < r_on_shadow);
    w_adc_d     = w_active_next && (w_cnt_ext == (r_on_shadow >> 1));
    w_ps_d      = (w_cnt == '0);
    w_ss_done_d = (w_next_state == ST_RUN);
  end

  // --------------------------------------------------------------------------
  // On-time shadow register
  // --------------------------------------------------------------------------

  // Shadow reload: cleared at once on shutdown, otherwise changed only at
  // the period boundary. IDLE holds on_shadow at 0, so the soft-start step
  // from IDLE yields min(SS_STEP, target) for the first period.
  always_comb begin
    w_on_next = r_on_shadow;
    if (!w_active_next) begin
      w_on_next = '0;
    end else if (w_last) begin
      w_on_next = (r_state == ST_RUN) ? w_target : w_ss_upd;
    end
  end

  // Shadow register
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      r_on_shadow <= '0;
    end else begin
      r_on_shadow <= w_on_next;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic r_pwm;
  logic r_adc;
  logic r_ps;
  logic r_ss_done;

  // Register every output so the gate driver sees glitch-free edges
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      r_pwm     <= 1'b0;
      r_adc     <= 1'b0;
      r_ps      <= 1'b0;
      r_ss_done <= 1'b0;
    end else begin
      r_pwm     <= w_pwm_d;
      r_adc     <= w_adc_d;
      r_ps      <= w_ps_d;
      r_ss_done <= w_ss_done_d;
    end
  end

  assign pwm_out      = r_pwm;
  assign adc_trig     = r_adc;
  assign period_start = r_ps;
  assign ss_done      = r_ss_done;
  assign status       = r_state;

`ifdef BUCK_PWM_COMP_EN
  // --------------------------------------------------------------------------
  // Complementary low-side drive
  // --------------------------------------------------------------------------
  localparam logic [c_on_w-1:0] c_dead_v  = c_on_w'(DEAD);
  localparam logic [c_on_w-1:0] c_low_end = c_on_w'(PERIOD - DEAD);

  logic w_low_d;
  logic r_low;

  // Low side is on from DEAD cycles after the high-side fall until DEAD
  // cycles before the next rise; when the low time is 2*DEAD or less this
  // window is empty and the low side stays off for the whole period.
  always_comb begin
    w_low_d = w_active_next &&
              (w_cnt_ext >= (r_on_shadow + c_dead_v)) &&
              (w_cnt_ext < c_low_end);
  end

  // Low-side output register
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      r_low <= 1'b0;
    end else begin
      r_low <= w_low_d;
    end
  end

  assign pwm_low = r_low;
`endif

endmodule
`default_nettype wire
